nes_oam_dma: RTL and testbench



---
 rtl/nes_oam_dma_if.sv | 44 ++++
 rtl/nes_oam_dma.sv | 145 ++++++++++++++
 tb/tb_nes_oam_dma.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/nes_oam_dma_if.sv
`default_nettype none
// ============================================================================
//  Module   : nes_oam_dma_if
//  Purpose  : CPU-snoop and shared-bus signal bundle for the NES sprite DMA.
//             The slave side is the DMA engine; the master side is the CPU/bus
//             environment that drives the snooped signals and read data.
//  Revision : 1.0  initial release
// ============================================================================
interface nes_oam_dma_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_nrw;
    logic [7:0]  bus_data_in;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic [7:0]  dma_data_out;
    logic        dma_nrw;
    logic        dma_done;

    modport slave (
        input  cpu_addr,
        input  cpu_data,
        input  cpu_nrw,
        input  bus_data_in,
        output dma_active,
        output dma_addr,
        output dma_data_out,
        output dma_nrw,
        output dma_done
    );

    modport master (
        output cpu_addr,
        output cpu_data,
        output cpu_nrw,
        output bus_data_in,
        input  dma_active,
        input  dma_addr,
        input  dma_data_out,
        input  dma_nrw,
        input  dma_done
    );
endinterface
`default_nettype wire

// File: rtl/nes_oam_dma.sv
`default_nettype none
// ============================================================================
//  Module   : nes_oam_dma
//  Purpose  : NES sprite DMA. Snoops CPU writes to $4014, halts the CPU and
//             copies 256 bytes from page $XX00-$XXFF to the PPU OAM data port,
//             one read/write pair per byte.
//  Options  : NES_DMA_ODD_ALIGN_EN - adds an ALIGN dummy cycle when the HALT
//             cycle falls on an odd parity cycle (514-cycle transfer).
//  Revision : 1.0  initial release
// ============================================================================
module nes_oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic          clk,
    input  logic          rst,
    nes_oam_dma_if.slave  bus
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_HALT  = 3'd1;
    localparam logic [2:0] c_READ  = 3'd2;
    localparam logic [2:0] c_WRITE = 3'd3;
`ifdef NES_DMA_ODD_ALIGN_EN
    localparam logic [2:0] c_ALIGN = 3'd4;
`endif

    logic [2:0] r_state;
    logic [2:0] w_state_next;
    logic [7:0] r_page;
    logic [7:0] r_index;
    logic [7:0] r_latch;
    logic       w_trigger;
    logic       w_last_byte;

    logic        w_active;
    logic [15:0] w_addr;
    logic [7:0]  w_data_out;
    logic        w_nrw;
    logic        w_done;

`ifdef NES_DMA_ODD_ALIGN_EN
    logic r_parity;

    // Free-running cycle parity, used to decide whether the halt needs aligning
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= ~r_parity;
        end
    end
`endif

    assign w_trigger   = (bus.cpu_addr == DMA_REG_ADDR) && (bus.cpu_nrw == 1'b0);
    assign w_last_byte = (r_index == 8'hFF);

    // Next-state decode; triggers are only honoured while idle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_trigger) begin
                    w_state_next = c_HALT;
                end
            end
            c_HALT: begin
`ifdef NES_DMA_ODD_ALIGN_EN
                w_state_next = r_parity ? c_ALIGN : c_READ;
`else
                w_state_next = c_READ;
`endif
            end
`ifdef NES_DMA_ODD_ALIGN_EN
            c_ALIGN: begin
                w_state_next = c_READ;
            end
`endif
            c_READ: begin
                w_state_next = c_WRITE;
            end
            c_WRITE: begin
                w_state_next = w_last_byte ? c_IDLE : c_READ;
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // State, page, byte index and read-data latch registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_page  <= 8'h00;
            r_index <= 8'h00;
            r_latch <= 8'h00;
        end else begin
            r_state <= w_state_next;
            if ((r_state == c_IDLE) && w_trigger) begin
                r_page  <= bus.cpu_data;
                r_index <= 8'h00;
            end
            if (r_state == c_READ) begin
                r_latch <= bus.bus_data_in;
            end
            if (r_state == c_WRITE) begin
                // 8-bit wrap is intentional; the FF->00 step ends the transfer
                r_index <= r_index + 8'h01;
            end
        end
    end

    // Moore output decode from the registered state
    always_comb begin
        w_active   = (r_state != c_IDLE);
        w_addr     = 16'h0000;
        w_data_out = 8'h00;
        w_nrw      = 1'b1;
        w_done     = 1'b0;
        case (r_state)
            c_READ: begin
                // Page and index are concatenated, so no carry into bit 16
                w_addr = {r_page, r_index};
            end
            c_WRITE: begin
                w_addr     = OAM_DATA_ADDR;
                w_data_out = r_latch;
                w_nrw      = 1'b0;
                w_done     = w_last_byte;
            end
            default: begin
                w_addr = 16'h0000;
            end
        endcase
    end

    assign bus.dma_active   = w_active;
    assign bus.dma_addr     = w_addr;
    assign bus.dma_data_out = w_data_out;
    assign bus.dma_nrw      = w_nrw;
    assign bus.dma_done     = w_done;

endmodule
`default_nettype wire

// File: tb/tb_nes_oam_dma.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nes_oam_dma
//  Purpose  : Directed self-checking bench for the NES sprite DMA.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nes_oam_dma;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nes_oam_dma_if bus_if ();

    nes_oam_dma dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // Memory model: byte at any address is its low byte XOR 5A
    assign bus_if.bus_data_in = bus_if.dma_addr[7:0] ^ 8'h5A;

    int checks = 0;
    int passed = 0;

    // Cycle parity model (0 in the cycle after the reset edge)
    logic [31:0] pc;
    always @(posedge clk) begin
        if (rst) pc <= 32'd0;
        else     pc <= pc + 32'd1;
    end

    logic [15:0] tr_addr [0:599];
    logic        tr_nrw  [0:599];
    logic [7:0]  tr_data [0:599];
    logic        tr_done [0:599];
    int          n_act;
    logic        hp;

    task automatic drive_idle();
        bus_if.cpu_addr = 16'h0000;
        bus_if.cpu_data = 8'h00;
        bus_if.cpu_nrw  = 1'b1;
    endtask

    task automatic drive_trig(input logic [7:0] page);
        bus_if.cpu_addr = 16'h4014;
        bus_if.cpu_data = page;
        bus_if.cpu_nrw  = 1'b0;
    endtask

    // Trigger on one edge; returns at the negedge of the first (HALT) cycle
    task automatic fire(input logic [7:0] page);
        @(negedge clk);
        drive_trig(page);
        @(negedge clk);
        drive_idle();
    endtask

    // Record one transfer; optionally re-trigger (page 03) in cycle retrig_at
    task automatic capture(input int retrig_at);
        n_act = 0;
        hp    = pc[0];
        for (int c = 0; c < 600; c++) begin
            if (!bus_if.dma_active) begin
                drive_idle();
                break;
            end
            tr_addr[c] = bus_if.dma_addr;
            tr_nrw[c]  = bus_if.dma_nrw;
            tr_data[c] = bus_if.dma_data_out;
            tr_done[c] = bus_if.dma_done;
            n_act++;
            if (c == retrig_at) drive_trig(8'h03);
            else                drive_idle();
            @(negedge clk);
        end
    endtask

    function automatic int lead_calc();
`ifdef NES_DMA_ODD_ALIGN_EN
        return 1 + int'(hp);
`else
        return 1;
`endif
    endfunction

    // Count deviations of the recorded trace from the expected bus sequence
    function automatic int trace_errs(input logic [7:0] page, input int lead);
        int errs = 0;
        for (int c = 0; c < lead + 512 && c < n_act; c++) begin
            if (c < lead) begin
                if (tr_addr[c] !== 16'h0000 || tr_nrw[c] !== 1'b1 || tr_done[c] !== 1'b0) errs++;
            end else begin
                int k = c - lead;
                logic [7:0] b = 8'((k / 2));
                if ((k % 2) == 0) begin
                    if (tr_addr[c] !== {page, b} || tr_nrw[c] !== 1'b1 || tr_done[c] !== 1'b0) errs++;
                end else begin
                    if (tr_addr[c] !== 16'h2004 || tr_nrw[c] !== 1'b0 ||
                        tr_data[c] !== (b ^ 8'h5A) || tr_done[c] !== (b == 8'hFF)) errs++;
                end
            end
        end
        return errs;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        checks++; if (bus_if.dma_active !== 1'b0) $display("FAIL reset_active got %b want 0", bus_if.dma_active); else passed++;
        checks++; if (bus_if.dma_nrw !== 1'b1) $display("FAIL reset_nrw got %b want 1", bus_if.dma_nrw); else passed++;
        checks++; if (bus_if.dma_addr !== 16'h0000) $display("FAIL reset_addr got %h want 0000", bus_if.dma_addr); else passed++;
        checks++; if (bus_if.dma_done !== 1'b0) $display("FAIL reset_done got %b want 0", bus_if.dma_done); else passed++;
        checks++; if (bus_if.dma_data_out !== 8'h00) $display("FAIL reset_data got %h want 00", bus_if.dma_data_out); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_basic_copy();
        int lead, e, dn;
        fire(8'h02);
        capture(-1);
        lead = lead_calc();
        e = trace_errs(8'h02, lead);
        dn = 0;
        for (int c = 0; c < n_act; c++) if (tr_done[c] === 1'b1) dn++;
        checks++; if (n_act !== lead + 512) $display("FAIL basic_active_cycles got %0d want %0d", n_act, lead + 512); else passed++;
        checks++; if (e !== 0) $display("FAIL basic_trace got %0d errors want 0", e); else passed++;
        checks++; if (dn !== 1) $display("FAIL basic_done_pulses got %0d want 1", dn); else passed++;
        checks++; if (tr_addr[lead] !== 16'h0200) $display("FAIL basic_first_read got %h want 0200", tr_addr[lead]); else passed++;
        checks++; if (bus_if.dma_nrw !== 1'b1 || bus_if.dma_addr !== 16'h0000)
            $display("FAIL basic_idle_after got nrw=%b addr=%h want 1/0000", bus_if.dma_nrw, bus_if.dma_addr); else passed++;
    endtask

    task automatic test_alignment();
        for (int s = 0; s < 2; s++) begin
            int lead;
            logic [7:0] pg;
            pg = 8'h10 + 8'(s);
            if (s == 1) @(negedge clk);
            fire(pg);
            capture(-1);
            lead = lead_calc();
            checks++; if (n_act !== lead + 512) $display("FAIL align%0d_cycles got %0d want %0d", s, n_act, lead + 512); else passed++;
            checks++; if (tr_addr[lead] !== {pg, 8'h00} || tr_nrw[lead] !== 1'b1)
                $display("FAIL align%0d_first_read got %h want %h", s, tr_addr[lead], {pg, 8'h00}); else passed++;
        end
    endtask

    task automatic test_page_ff_retrigger();
        int lead, e, wr;
        fire(8'hFF);
        capture(100);
        lead = lead_calc();
        e = trace_errs(8'hFF, lead);
        wr = 0;
        for (int c = 0; c < n_act; c++) if (tr_nrw[c] === 1'b0) wr++;
        checks++; if (n_act !== lead + 512) $display("FAIL pageff_cycles got %0d want %0d", n_act, lead + 512); else passed++;
        checks++; if (e !== 0) $display("FAIL pageff_trace got %0d errors want 0", e); else passed++;
        checks++; if (wr !== 256) $display("FAIL pageff_writes got %0d want 256", wr); else passed++;
        checks++; if (tr_addr[lead + 510] !== 16'hFFFF) $display("FAIL pageff_last_read got %h want FFFF", tr_addr[lead + 510]); else passed++;
    endtask

    task automatic test_back_to_back();
        int lead, act;
        fire(8'h05);
        lead = lead_calc();
        capture(lead + 511);
        act = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus_if.dma_active !== 1'b0) act++;
            @(negedge clk);
        end
        checks++; if (n_act !== lead + 512) $display("FAIL b2b_cycles got %0d want %0d", n_act, lead + 512); else passed++;
        checks++; if (act !== 0) $display("FAIL b2b_retrigger_ignored got %0d active cycles want 0", act); else passed++;
    endtask

    task automatic test_reset_mid();
        int lead, e;
        fire(8'h09);
        lead = lead_calc();
        for (int c = 0; c < lead + 201; c++) @(negedge clk);
        checks++; if (bus_if.dma_addr !== 16'h2004 || bus_if.dma_data_out !== 8'h3E)
            $display("FAIL midrst_byte100 got addr=%h data=%h want 2004/3E", bus_if.dma_addr, bus_if.dma_data_out); else passed++;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus_if.dma_active !== 1'b0 || bus_if.dma_nrw !== 1'b1)
            $display("FAIL midrst_outputs got active=%b nrw=%b want 0/1", bus_if.dma_active, bus_if.dma_nrw); else passed++;
        checks++; if (bus_if.dma_addr !== 16'h0000 || bus_if.dma_data_out !== 8'h00 || bus_if.dma_done !== 1'b0)
            $display("FAIL midrst_values got addr=%h data=%h done=%b want 0000/00/0",
                     bus_if.dma_addr, bus_if.dma_data_out, bus_if.dma_done); else passed++;
        rst = 1'b0;
        fire(8'h04);
        capture(-1);
        lead = lead_calc();
        e = trace_errs(8'h04, lead);
        checks++; if (n_act !== lead + 512) $display("FAIL midrst_restart_cycles got %0d want %0d", n_act, lead + 512); else passed++;
        checks++; if (e !== 0 || tr_addr[lead] !== 16'h0400)
            $display("FAIL midrst_restart_trace got %0d errors first=%h want 0/0400", e, tr_addr[lead]); else passed++;
    endtask

    task automatic test_reset_trigger();
        int act = 0;
        @(negedge clk);
        rst = 1'b1;
        drive_trig(8'h06);
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        for (int i = 0; i < 4; i++) begin
            if (bus_if.dma_active !== 1'b0) act++;
            @(negedge clk);
        end
        checks++; if (act !== 0) $display("FAIL rst_vs_trigger got %0d active cycles want 0", act); else passed++;
    endtask

    task automatic test_non_trigger();
        int act = 0;
        @(negedge clk);
        bus_if.cpu_addr = 16'h4014; bus_if.cpu_data = 8'h02; bus_if.cpu_nrw = 1'b1;
        @(negedge clk);
        if (bus_if.dma_active !== 1'b0) act++;
        bus_if.cpu_addr = 16'h4015; bus_if.cpu_data = 8'h02; bus_if.cpu_nrw = 1'b0;
        @(negedge clk);
        drive_idle();
        for (int i = 0; i < 4; i++) begin
            if (bus_if.dma_active !== 1'b0) act++;
            @(negedge clk);
        end
        checks++; if (act !== 0) $display("FAIL non_trigger got %0d active cycles want 0", act); else passed++;
    endtask

    task automatic test_page_zero();
        int lead, e;
        fire(8'h00);
        capture(-1);
        lead = lead_calc();
        e = trace_errs(8'h00, lead);
        checks++; if (n_act !== lead + 512) $display("FAIL page00_cycles got %0d want %0d", n_act, lead + 512); else passed++;
        checks++; if (e !== 0) $display("FAIL page00_trace got %0d errors want 0", e); else passed++;
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_basic_copy();
        test_alignment();
        test_page_ff_retrigger();
        test_back_to_back();
        test_reset_mid();
        test_reset_trigger();
        test_non_trigger();
        test_page_zero();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
